// File: rtl/dmem_arbiter_if.sv
// Bundle between the CPU port, the debug/comm port, the shared data memory and the arbiter status.
// The arbiter connects through the slave modport; requesters and the memory model use master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic [1:0]        cpu_we;
    logic [2:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic [1:0]        dbg_we;
    logic [2:0]        dbg_size;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [1:0]        mem_we;
    logic [2:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_we, mem_size, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (cpu/dbg) arbiter onto one data memory; DMEM_ARB_ROUND_ROBIN_EN selects round-robin, else dbg has fixed priority.
// Latency: request sampled in IDLE at edge n, ack pulses in the cycle after edge n+1; one access per 3 cycles.
// Backpressure: requests are level-held; a loser keeps req high and is served later, never dropped.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t            state;
    logic [1:0]        mem_we_q;
    logic [2:0]        mem_size_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              cpu_ack_q;
    logic              dbg_ack_q;
    logic              busy_q;
    logic              owner_q;
    logic              any_req;
    logic              grant_dbg;

    assign any_req = bus.cpu_req | bus.dbg_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_dbg;

    always_comb begin
        grant_dbg = bus.dbg_req;
        if (bus.cpu_req && bus.dbg_req) begin
            grant_dbg = ~last_dbg;
        end
    end

    // Reset to dbg so the first contended grant goes to the cpu.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dbg <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_dbg <= grant_dbg;
        end
    end
`else
    assign grant_dbg = bus.dbg_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_we_q    <= 2'b00;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q     <= grant_dbg;
                        mem_we_q    <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
                        mem_size_q  <= grant_dbg ? bus.dbg_size  : bus.cpu_size;
                        mem_addr_q  <= grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                        mem_wdata_q <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                        busy_q      <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_we_q still holds the granted code here; it drops as we leave.
                    if (mem_we_q == 2'b00) begin
                        if (owner_q) begin
                            dbg_rdata_q <= bus.mem_rdata;
                        end else begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end
                    end
                    mem_we_q  <= 2'b00;
                    cpu_ack_q <= ~owner_q;
                    dbg_ack_q <= owner_q;
                    state     <= ACK;
                end
                ACK: begin
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected memory accesses, a negedge monitor pops and checks them.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    // Memory model: fixed pattern derived from the address.
    assign ifc.mem_rdata = (ifc.mem_addr == 32'h10) ? 32'hDEADBEEF
                                                     : (32'hA5A5_0000 | {16'h0, ifc.mem_addr[15:0]});

    typedef struct {
        bit          port;
        logic [1:0]  we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          req_cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   pend_vld = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic push(bit port, logic [1:0] we, logic [2:0] size, logic [31:0] addr,
                        logic [31:0] wdata, logic [31:0] rdata, int rc);
        exp_t e;
        e.port = port; e.we = we; e.size = size; e.addr = addr;
        e.wdata = wdata; e.rdata = rdata; e.req_cyc = rc;
        exp_q.push_back(e);
    endtask

    task automatic drive_port(bit port, logic [1:0] we, logic [2:0] size, logic [31:0] addr,
                              logic [31:0] wdata);
        if (port) begin
            ifc.dbg_we = we; ifc.dbg_size = size; ifc.dbg_addr = addr; ifc.dbg_wdata = wdata;
        end else begin
            ifc.cpu_we = we; ifc.cpu_size = size; ifc.cpu_addr = addr; ifc.cpu_wdata = wdata;
        end
    endtask

    task automatic wait_acks(int n);
        int got = 0;
        int t   = 0;
        while (got < n && t < 40 * n) begin
            @(negedge clk);
            t++;
            if (ifc.cpu_ack || ifc.dbg_ack) got++;
        end
        if (got < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout got=%0d required=%0d", got, n);
        end
    endtask

    task automatic single(bit port, logic [1:0] we, logic [2:0] size, logic [31:0] addr,
                          logic [31:0] wdata, logic [31:0] rdata);
        @(negedge clk); #1;
        drive_port(port, we, size, addr, wdata);
        push(port, we, size, addr, wdata, rdata, cyc);
        if (port) ifc.dbg_req = 1'b1; else ifc.cpu_req = 1'b1;
        wait_acks(1);
        if (port) ifc.dbg_req = 1'b0; else ifc.cpu_req = 1'b0;
    endtask

    // Monitor: access cycle is busy without ack; the ack follows exactly one cycle later.
    initial begin
        exp_t        cur;
        logic [31:0] m_cpu_rdata = '0;
        logic [31:0] m_dbg_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_cpu_rdata = '0;
                m_dbg_rdata = '0;
                pend_vld    = 1'b0;
            end else begin
                if (ifc.busy && !ifc.cpu_ack && !ifc.dbg_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_access", 32'd1, 32'd0);
                    end else begin
                        cur      = exp_q.pop_front();
                        pend_vld = 1'b1;
                        chk("acc_owner", {31'd0, ifc.owner}, {31'd0, cur.port});
                        chk("acc_mem_we", {30'd0, ifc.mem_we}, {30'd0, cur.we});
                        chk("acc_mem_size", {29'd0, ifc.mem_size}, {29'd0, cur.size});
                        chk("acc_mem_addr", ifc.mem_addr, cur.addr);
                        chk("acc_mem_wdata", ifc.mem_wdata, cur.wdata);
                    end
                end else begin
                    chk("idle_mem_we", {30'd0, ifc.mem_we}, 32'd0);
                end
                if (ifc.cpu_ack || ifc.dbg_ack) begin
                    if (!pend_vld) begin
                        chk("unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        chk("ack_cpu", {31'd0, ifc.cpu_ack}, {31'd0, ~cur.port});
                        chk("ack_dbg", {31'd0, ifc.dbg_ack}, {31'd0, cur.port});
                        chk("ack_busy", {31'd0, ifc.busy}, 32'd1);
                        if (cur.we == 2'b00) begin
                            if (cur.port) m_dbg_rdata = cur.rdata;
                            else          m_cpu_rdata = cur.rdata;
                        end
                        chk("cpu_rdata", ifc.cpu_rdata, m_cpu_rdata);
                        chk("dbg_rdata", ifc.dbg_rdata, m_dbg_rdata);
                        if (cur.req_cyc >= 0) chk("ack_latency", cyc, cur.req_cyc + 2);
                        pend_vld = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        rst_n = 1'b0;
        ifc.cpu_req = 1'b0; ifc.dbg_req = 1'b0;
        drive_port(1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
        drive_port(1'b1, 2'b00, 3'd0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_owner", {31'd0, ifc.owner}, 32'd0);
        chk("rst_mem_we", {30'd0, ifc.mem_we}, 32'd0);
        chk("rst_mem_size", {29'd0, ifc.mem_size}, 32'd0);
        chk("rst_mem_addr", ifc.mem_addr, 32'd0);
        chk("rst_mem_wdata", ifc.mem_wdata, 32'd0);
        chk("rst_cpu_rdata", ifc.cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", ifc.dbg_rdata, 32'd0);
        chk("rst_acks", {30'd0, ifc.cpu_ack, ifc.dbg_ack}, 32'd0);
        #1 rst_n = 1'b1;

        single(1'b0, 2'b00, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF);
        single(1'b1, 2'b11, 3'd2, 32'h08, 32'h000000A5, 32'h0);
        single(1'b0, 2'b01, 3'd0, 32'h04, 32'h00000055, 32'h0);
        single(1'b1, 2'b00, 3'd1, 32'h24, 32'h0,        32'hA5A50024);

        // Contention with both requests held; last grant above was dbg.
        @(negedge clk); #1;
        drive_port(1'b0, 2'b00, 3'd2, 32'h20, 32'h0);
        drive_port(1'b1, 2'b01, 3'd0, 32'h30, 32'h00001234);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 2'b00, 3'd2, 32'h20, 32'h0, 32'hA5A50020, -1);
            push(1'b1, 2'b01, 3'd0, 32'h30, 32'h00001234, 32'h0, -1);
        end
        ifc.cpu_req = 1'b1; ifc.dbg_req = 1'b1;
        wait_acks(4);
        ifc.cpu_req = 1'b0; ifc.dbg_req = 1'b0;
`else
        for (int i = 0; i < 4; i++) push(1'b1, 2'b01, 3'd0, 32'h30, 32'h00001234, 32'h0, -1);
        push(1'b0, 2'b00, 3'd2, 32'h20, 32'h0, 32'hA5A50020, -1);
        ifc.cpu_req = 1'b1; ifc.dbg_req = 1'b1;
        wait_acks(4);
        ifc.dbg_req = 1'b0;
        wait_acks(1);
        ifc.cpu_req = 1'b0;
`endif

        // One-cycle req pulse with request fields changed during ACCESS.
        @(negedge clk); #1;
        drive_port(1'b0, 2'b00, 3'd2, 32'h44, 32'h0);
        push(1'b0, 2'b00, 3'd2, 32'h44, 32'h0, 32'hA5A50044, cyc);
        ifc.cpu_req = 1'b1;
        @(negedge clk); #1;
        ifc.cpu_req  = 1'b0;
        ifc.cpu_addr = 32'h99;
        ifc.dbg_addr = 32'h77;
        wait_acks(1);

        // Reset during a write ACCESS; dbg_req stays pending across it.
        @(negedge clk); #1;
        drive_port(1'b1, 2'b11, 3'd1, 32'h50, 32'hCAFEF00D);
        ifc.dbg_req = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_mem_we", {30'd0, ifc.mem_we}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", {30'd0, ifc.mem_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("mid_rst_acks", {30'd0, ifc.cpu_ack, ifc.dbg_ack}, 32'd0);
        chk("mid_rst_cpu_rdata", ifc.cpu_rdata, 32'd0);
        @(negedge clk); #1;
        push(1'b1, 2'b11, 3'd1, 32'h50, 32'hCAFEF00D, 32'h0, cyc);
        rst_n = 1'b1;
        wait_acks(1);
        ifc.dbg_req = 1'b0;

        t = 0;
        while ((exp_q.size() != 0 || pend_vld) && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width of all ports.
REQ-002 SHALL have parameter: DATA_W, 32, data width of all ports.
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: cpu_req in 1 | cpu_we in 2 (00 = read, else write-size code) | cpu_size in 3 (load size code) | cpu_addr in ADDR_W | cpu_wdata in DATA_W.
REQ-006 SHALL have ports: cpu_ack out 1, one-cycle done pulse | cpu_rdata out DATA_W, read result.
REQ-007 SHALL have ports dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, same widths and meaning, for the communication/debug port.
REQ-008 SHALL have ports: mem_we out 2 | mem_size out 3 | mem_addr out ADDR_W | mem_wdata out DATA_W | mem_rdata in DATA_W, combinational read data from memory.
REQ-009 SHALL have ports: busy out 1, transaction in progress | owner out 1, 0 = cpu, 1 = dbg, port of the current or last grant.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, ACK.
REQ-011 IDLE: no req -> stay. Any req -> choose winner, register its we/size/addr/wdata, set owner, go ACCESS.
REQ-012 ACCESS: drive mem_* from registered fields for exactly one cycle; capture mem_rdata into the winner's rdata register at the clock edge; go ACK.
REQ-013 ACK: pulse winner's ack high for exactly one cycle; go IDLE.
REQ-014 Latency SHALL be fixed: req sampled in IDLE at edge n -> ack high during cycle n+2. Throughput is one access per 3 cycles.
REQ-015 mem_we SHALL be 00 in every state except ACCESS. mem_addr, mem_size and mem_wdata SHALL hold the last registered values outside ACCESS.
REQ-016 A rdata register SHALL update only on a read (we = 00) for its own port, and SHALL hold otherwise.
REQ-017 Request fields SHALL be sampled only in IDLE. Changes during ACCESS/ACK SHALL be ignored.
REQ-018 A req dropped mid-transaction SHALL NOT abort it. Ack still pulses.
REQ-019 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-020 busy SHALL be high in ACCESS and ACK, low in IDLE.
REQ-021 Single requester SHALL always be granted. The losing requester waits; it is never dropped.
REQ-022 size and we codes SHALL pass through unmodified; invalid codes are not checked.

Reset
REQ-023 reset low SHALL force asynchronously: state IDLE, mem_we 00, mem_size 0, mem_addr 0, mem_wdata 0, cpu_ack 0, dbg_ack 0, cpu_rdata 0, dbg_rdata 0, busy 0, owner 0, last-served = dbg.
REQ-024 reset asserted mid-ACCESS SHALL drop mem_we to 00 immediately. No ack is produced for that transaction.
REQ-025 After reset deasserts, the first edge SHALL evaluate requests in IDLE.

Configuration
REQ-026 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous req, grant the port not served last. last-served updates at every grant.
REQ-027 Macro undefined: on simultaneous req, dbg always wins (fixed priority). The last-served register is not built.

Verification
REQ-028 cpu read only, cpu_addr=0x10, mem_rdata=0xDEADBEEF -> mem_we=00 for 1 cycle; cpu_ack at n+2; cpu_rdata=0xDEADBEEF; dbg_rdata unchanged.
REQ-029 dbg write only, dbg_we=11, dbg_addr=0x8, dbg_wdata=0x000000A5 -> mem_we=11, mem_addr=0x8, mem_wdata=0xA5 for exactly 1 cycle; dbg_ack at n+2; no cpu_ack.
REQ-030 cpu and dbg held high for 4 transactions, RR enabled -> grant order cpu, dbg, cpu, dbg. RR disabled -> dbg on every grant while dbg_req is held.
REQ-031 cpu_req pulsed 1 cycle, then low; dbg_addr changed during ACCESS -> full transaction completes; cpu_ack pulses; mem_addr shows the value sampled in IDLE.
REQ-032 reset driven low in ACCESS of a write -> mem_we=00 same cycle, busy=0, no ack. After release, a pending dbg_req is granted with ack 2 cycles later.
